// File: rtl/temporizador_pkg.sv
// temporizador_pkg: shared tile constants, timer state enum and BCD decrement for the countdown overlay.
package temporizador_pkg;
  localparam int TILE_LOG2 = 4;
  localparam logic [3:0] BLANK_GLYPH = 4'd10;
  typedef enum logic [1:0] {IDLE, RUN, DONE} tstate_e;
  // Borrow ripples up from the least significant digit; a 0 digit wraps to 9.
  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    logic b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (b) begin
        r[i*4+:4] = v[i*4+:4] == 4'd0 ? 4'd9 : v[i*4+:4] - 4'd1;
        b = v[i*4+:4] == 4'd0;
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/temporizador_overlay_if.sv
// temporizador_overlay_if: scan position, tick/start/gate requests and per-channel timer outputs.
interface temporizador_overlay_if #(parameter int N_CH = 2);
  logic [9:0] PosH;
  logic [9:0] PosV;
  logic SecTick;
  logic [N_CH-1:0] Start;
  logic [N_CH-1:0] Gate;
  logic [N_CH-1:0] EnaTimer;
  logic [N_CH-1:0] Zero;
  logic [N_CH-1:0] Expired;
  modport master(output PosH, PosV, SecTick, Start, Gate, input EnaTimer, Zero, Expired);
  modport slave(input PosH, PosV, SecTick, Start, Gate, output EnaTimer, Zero, Expired);
endinterface

// File: rtl/font_rom_num16x16_sync.sv
// font_rom_num16x16_sync: 256x16 digit font, address {glyph, row}, one-cycle registered read.
module font_rom_num16x16_sync (
  input  logic        clk,
  input  logic [7:0]  addr_i,
  output logic [15:0] data_o
);
  // Seven-segment glyphs {a,b,c,d,e,f,g}; codes 10..15 are blank.
  localparam logic [6:0] SEG [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                      7'h7F, 7'h7B, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
  localparam logic [15:0] BAR = 16'h3FFC;
  localparam logic [15:0] LFT = 16'h3000;
  localparam logic [15:0] RGT = 16'h000C;
  logic [6:0] seg;
  logic [3:0] r;
  logic [15:0] row_d;
  always_comb begin
    seg = SEG[addr_i[7:4]];
    r = addr_i[3:0];
    row_d = (r == 4'd1 || r == 4'd2) ? (seg[6] ? BAR : '0)
          : (r >= 4'd3 && r <= 4'd6) ? ((seg[1] ? LFT : '0) | (seg[5] ? RGT : '0))
          : (r == 4'd7 || r == 4'd8) ? (seg[0] ? BAR : '0)
          : (r >= 4'd9 && r <= 4'd12) ? ((seg[2] ? LFT : '0) | (seg[4] ? RGT : '0))
          : (r == 4'd13 || r == 4'd14) ? (seg[3] ? BAR : '0) : '0;
  end
  always_ff @(posedge clk) data_o <= row_d;
endmodule

// File: rtl/temporizador_overlay.sv
// temporizador_overlay: N_CH BCD countdown timers drawn as 16x16 digits on the VGA overlay.
// TEMPORIZADOR_BLANK_LEADING_EN blanks leading zero digits (least significant digit always drawn).
module temporizador_overlay
  import temporizador_pkg::*;
#(
  parameter int N_CH = 2,
  parameter int DIGITS = 2,
  parameter logic [DIGITS*4-1:0] LOAD_BCD = 8'h15,
  parameter int ROW_TILE = 28,
  parameter int COL_BASE = 5,
  parameter int COL_STEP = 19
) (
  input logic Clk,
  input logic Reset,
  temporizador_overlay_if.slave bus
);
  localparam int W = DIGITS * 4;
  logic [N_CH-1:0][W-1:0] cnt;
  logic [N_CH-1:0] zero_v, exp_v;
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    tstate_e state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic zero_q, exp_q, exp_d;
    always_ff @(posedge Clk) begin
      if (Reset) begin
        state_q <= IDLE;
        cnt_q <= '0;
        zero_q <= 1'b1;
        exp_q <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q <= cnt_d;
        zero_q <= cnt_d == '0;
        exp_q <= exp_d;
      end
    end
    always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      exp_d = 1'b0;
      if (bus.Start[c]) begin
        cnt_d = LOAD_BCD;
        state_d = LOAD_BCD == '0 ? DONE : RUN;
      end else if (state_q == RUN && bus.SecTick) begin
        cnt_d = W'(bcd_dec(16'(cnt_q)));
        exp_d = cnt_d == '0;
        state_d = exp_d ? DONE : RUN;
      end
    end
    assign cnt[c] = cnt_q;
    assign zero_v[c] = zero_q;
    assign exp_v[c] = exp_q;
  end
  assign bus.Zero = zero_v;
  assign bus.Expired = exp_v;
  logic [5:0] tcol, trow;
  logic [3:0] g, glyph;
  logic [N_CH-1:0] hit_d, hit1_q, hit2_q, gate1_q, gate2_q, ena_q;
  logic [7:0] addr_q;
  logic [3:0] col1_q, col2_q;
  logic [15:0] row_data;
`ifdef TEMPORIZADOR_BLANK_LEADING_EN
  logic lead;
`endif
  assign tcol = bus.PosH[9:TILE_LOG2];
  assign trow = bus.PosV[9:TILE_LOG2];
  // Glyphs of overlapping tiles are OR-ed; only a misconfiguration can overlap.
  always_comb begin
    hit_d = '0;
    glyph = '0;
    g = '0;
`ifdef TEMPORIZADOR_BLANK_LEADING_EN
    lead = 1'b1;
`endif
    for (int c = 0; c < N_CH; c++) begin
`ifdef TEMPORIZADOR_BLANK_LEADING_EN
      lead = 1'b1;
`endif
      for (int d = 0; d < DIGITS; d++) begin
        g = cnt[c][(DIGITS-1-d)*4+:4];
`ifdef TEMPORIZADOR_BLANK_LEADING_EN
        lead = lead && g == 4'd0 && d != DIGITS - 1;
        g = lead ? BLANK_GLYPH : g;
`endif
        if (int'(trow) == ROW_TILE && int'(tcol) == COL_BASE + c * COL_STEP + d) begin
          hit_d[c] = 1'b1;
          glyph = glyph | g;
        end
      end
    end
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      addr_q <= '0;
      hit1_q <= '0;
      gate1_q <= '0;
      col1_q <= '0;
      hit2_q <= '0;
      gate2_q <= '0;
      col2_q <= '0;
      ena_q <= '0;
    end else begin
      addr_q <= {glyph, bus.PosV[3:0]};
      hit1_q <= hit_d;
      gate1_q <= bus.Gate;
      col1_q <= bus.PosH[3:0];
      hit2_q <= hit1_q;
      gate2_q <= gate1_q;
      col2_q <= col1_q;
      ena_q <= hit2_q & gate2_q & {N_CH{row_data[4'd15 - col2_q]}};
    end
  end
  font_rom_num16x16_sync u_rom (.clk(Clk), .addr_i(addr_q), .data_o(row_data));
  assign bus.EnaTimer = ena_q;
endmodule

// File: tb/tb_temporizador_overlay.sv
// tb_temporizador_overlay: directed countdown, borrow, priority, render, blanking and reset checks.
module tb_temporizador_overlay;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;
  temporizador_overlay_if #(.N_CH(2)) bus ();
  temporizador_overlay #(.N_CH(2)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));
  int tests = 0;
  int fails = 0;
  logic [6:0] s;
  logic [13:0] n;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge Clk);
    #1;
  endtask
  task automatic tick();
    bus.SecTick = 1'b1;
    step();
    bus.SecTick = 1'b0;
  endtask
  task automatic start(input logic [1:0] m);
    bus.Start = m;
    step();
    bus.Start = '0;
  endtask
  function automatic logic [6:0] seg(input int v);
    case (v)
      0: return 7'h7E;
      1: return 7'h30;
      2: return 7'h6D;
      3: return 7'h79;
      4: return 7'h33;
      5: return 7'h5B;
      6: return 7'h5F;
      7: return 7'h70;
      8: return 7'h7F;
      9: return 7'h7B;
      default: return 7'h00;
    endcase
  endfunction
  function automatic logic [13:0] num(input int v);
    logic [6:0] hi;
    hi = seg(v / 10);
`ifdef TEMPORIZADOR_BLANK_LEADING_EN
    if (v / 10 == 0) hi = 7'h00;
`endif
    return {hi, seg(v % 10)};
  endfunction
  // Samples one pixel per segment a..g of the tile, holding each position 3 cycles.
  task automatic read_tile(input int c, input int d, output logic [6:0] r);
    int xs[7] = '{7, 12, 12, 7, 2, 2, 7};
    int ys[7] = '{1, 4, 10, 13, 10, 4, 7};
    for (int k = 0; k < 7; k++) begin
      bus.PosH = 10'((5 + c * 19 + d) * 16 + xs[k]);
      bus.PosV = 10'(28 * 16 + ys[k]);
      repeat (3) step();
      r[6-k] = bus.EnaTimer[c];
    end
  endtask
  task automatic read_num(input int c, output logic [13:0] r);
    logic [6:0] hi, lo;
    read_tile(c, 0, hi);
    read_tile(c, 1, lo);
    r = {hi, lo};
  endtask
  task automatic scan(input logic [1:0] gate, input string tag);
    int tiles[4] = '{5, 6, 24, 25};
    logic [15:0] rows[4];
    logic [1:0] ex[64];
    logic b;
    rows[0] = 16'h000C;
    rows[1] = 16'h000C;
`ifdef TEMPORIZADOR_BLANK_LEADING_EN
    rows[2] = 16'h0000;
`else
    rows[2] = 16'h300C;
`endif
    rows[3] = 16'h300C;
    bus.Gate = gate;
    for (int i = 0; i < 64; i++) begin
      b = rows[i/16][15 - (i % 16)];
      ex[i] = i < 32 ? {1'b0, b & gate[0]} : {b & gate[1], 1'b0};
    end
    for (int i = 0; i < 66; i++) begin
      if (i < 64) begin
        bus.PosH = 10'(tiles[i/16] * 16 + i % 16);
        bus.PosV = 10'(28 * 16 + 3);
      end
      step();
      if (i >= 2) chk(tag, bus.EnaTimer, ex[i-2]);
    end
    bus.Gate = 2'b11;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.PosH = '0;
    bus.PosV = '0;
    bus.SecTick = 1'b0;
    bus.Start = '0;
    bus.Gate = 2'b11;
    repeat (3) step();
    chk("rst_zero", bus.Zero, 2'b11);
    chk("rst_expired", bus.Expired, 2'b00);
    chk("rst_ena", bus.EnaTimer, 2'b00);
    Reset = 1'b0;
    step();
    read_num(0, n);
    chk("idle_render", n, num(0));
    start(2'b01);
    chk("start_zero0", bus.Zero[0], 1'b0);
    chk("start_zero1", bus.Zero[1], 1'b1);
    read_num(0, n);
    chk("load15", n, num(15));
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk("tick_expired", bus.Expired[0], i == 15);
      chk("tick_zero", bus.Zero[0], i == 15);
      if (i == 15) begin
        step();
        chk("expired_once", bus.Expired[0], 1'b0);
      end
      if (i == 1 || i == 5 || i == 6 || i == 15) begin
        read_num(0, n);
        chk("countdown", n, num(15 - i));
      end
    end
    repeat (3) begin
      tick();
      chk("done_zero", bus.Zero[0], 1'b1);
      chk("done_expired", bus.Expired[0], 1'b0);
    end
    read_num(0, n);
    chk("done_hold", n, num(0));
    start(2'b10);
    repeat (8) tick();
    read_num(1, n);
    chk("ch1_07", n, num(7));
    bus.Start = 2'b10;
    bus.SecTick = 1'b1;
    step();
    bus.Start = '0;
    bus.SecTick = 1'b0;
    read_num(1, n);
    chk("start_prio", n, num(15));
    chk("done_ignores_tick", bus.Zero[0], 1'b1);
    repeat (4) tick();
    start(2'b01);
    repeat (3) tick();
    read_num(0, n);
    chk("ch0_12", n, num(12));
    read_num(1, n);
    chk("ch1_08", n, num(8));
    scan(2'b11, "scan_gate11");
    scan(2'b10, "scan_gate10");
    start(2'b01);
    repeat (10) tick();
    read_tile(0, 0, s);
`ifdef TEMPORIZADOR_BLANK_LEADING_EN
    chk("lead_tile5", s, 7'h00);
`else
    chk("lead_tile5", s, seg(0));
`endif
    read_tile(0, 1, s);
    chk("lead_tile6", s, seg(5));
    start(2'b01);
    repeat (6) tick();
    read_num(0, n);
    chk("ch0_09", n, num(9));
    bus.PosH = 10'(6 * 16 + 12);
    bus.PosV = 10'(28 * 16 + 4);
    repeat (3) step();
    chk("pre_rst_ena", bus.EnaTimer[0], 1'b1);
    Reset = 1'b1;
    step();
    chk("midrst_ena", bus.EnaTimer, 2'b00);
    chk("midrst_zero", bus.Zero, 2'b11);
    chk("midrst_expired", bus.Expired, 2'b00);
    Reset = 1'b0;
    step();
    chk("post_rst_ena1", bus.EnaTimer, 2'b00);
    step();
    chk("post_rst_ena2", bus.EnaTimer, 2'b00);
    step();
    chk("post_rst_ena3", bus.EnaTimer[0], 1'b1);
    tick();
    chk("idle_ignores_tick", bus.Zero[0], 1'b1);
    read_num(0, n);
    chk("post_rst_count", n, num(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/temporizador_overlay.md
# temporizador_overlay

Parametrised multi-channel countdown timer with on-screen digit rendering for the VGA overlay path. Each of N_CH channels holds a BCD countdown that decrements on a one-second tick, and renders its value as 16x16 font digits at a fixed tile row and per-channel column. The block sits between the VGA sync counters (PosH/PosV) and the colour mixer. It asserts one pixel-enable per channel, gated by that channel's external Gate input (the opposing light's red state).

## Interface
Parameters:
- N_CH, 2: number of timer channels.
- DIGITS, 2: BCD digits per channel (1..4).
- LOAD_BCD, 8'h15: value loaded on Start, DIGITS*4 bits, packed BCD.
- ROW_TILE, 28: tile row (PosV[9:4]) where all timers are drawn.
- COL_BASE, 5: tile column of channel 0, most significant digit.
- COL_STEP, 19: tile-column offset between consecutive channels (channel 1 lands at 24).

Ports:
- Clk  in  1  pixel clock; the only clock.
- Reset  in  1  synchronous, active-high reset.
- PosH  in  10  horizontal pixel position.
- PosV  in  10  vertical pixel position.
- SecTick  in  1  one-cycle decrement pulse (1 Hz strobe).
- Start  in  N_CH  per-channel load and run request, one-cycle pulse.
- Gate  in  N_CH  per-channel display enable (level).
- EnaTimer  out  N_CH  per-channel pixel-on, registered.
- Zero  out  N_CH  count equals 0, level, registered.
- Expired  out  N_CH  one-cycle pulse when the count reaches 0 while running.

## Operation
- Each channel runs an FSM with states IDLE, RUN and DONE.
  - Reset: state IDLE, count 0, Zero=1, Expired=0, EnaTimer=0.
  - Start[c] in any state: count <= LOAD_BCD, state <= RUN. Start takes priority over a SecTick in the same cycle.
  - RUN with SecTick: BCD decrement. A digit at 0 wraps to 9 and borrows from the next digit.
  - When the decrement result is 0: state <= DONE and Expired[c]=1 on the next cycle only.
  - DONE: count holds at 0 and SecTick is ignored.
  - IDLE: SecTick is ignored.
  - If LOAD_BCD=0, Start goes straight to DONE with no Expired pulse.
- Rendering:
  - Channel c, digit d (d=0 is most significant) occupies tile column COL_BASE + c*COL_STEP + d in row ROW_TILE.
  - On a tile hit, the font ROM address is {digit, PosV[3:0]}.
  - Pixel = row_data[15 - PosH[3:0]], MSB leftmost.
  - EnaTimer[c] = hit_c & pixel & Gate[c].
  - Gate is sampled together with PosH/PosV, so it is aligned through the pipeline.
  - The count is rendered in every state, including IDLE and DONE.
  - Overlapping tiles from a misconfiguration may assert several bits; no arbitration is done.
- Font: glyph codes 0..9 are digits; codes 10..15 are blank (all rows zero).

## Timing
- Count update: registered, 1 cycle after Start/SecTick. Zero follows the count in the same cycle.
- Render pipeline is 3 cycles from PosH/PosV/Gate to EnaTimer:
  - S1: tile decode, ROM address, registered col/hit/gate.
  - S2: synchronous ROM read, delayed col/hit/gate.
  - S3: bit select and AND, registered output.
- A count change between scan positions takes effect on the next pixel sampled in S1. No tearing guard.
- Reset mid-operation: all pipeline registers clear, so EnaTimer=0 for 3 cycles after release.

## Configuration
- TEMPORIZADOR_BLANK_LEADING_EN
  - Defined: leading zero digits (all digits more significant than the first nonzero digit) render as blank code 10. The least significant digit always renders. Example: 05 shows " 5".
  - Undefined: all DIGITS digits render, including leading zeros.

## Structure
- Shared package temporizador_pkg holds:
  - tile size constant TILE_LOG2=4.
  - BLANK_GLYPH=4'd10.
  - Timer state enum (IDLE, RUN, DONE).
  - BCD-decrement function.
- Sub-module font_rom_num16x16_sync: 256x16 synchronous ROM, address {glyph[3:0], row[3:0]}, 1-cycle registered read.
- Channels are produced by a generate loop over N_CH. A single ROM is shared, since at most one tile is hit per pixel.

## Test plan
- Reset, then Start[0], then 15 SecTicks (LOAD_BCD=15):
  - count 15 → 14 … 00.
  - Expired[0] pulses exactly once, 1 cycle after the 15th tick.
  - Zero[0]=1 from then on; further ticks leave the count at 00.
- Start[1] and SecTick in the same cycle while channel 1 counts 07 → count=15, no decrement.
- BCD borrow: count 10 plus one SecTick → 09. Count 00 in DONE plus a SecTick → stays 00.
- Scan PosV=28*16+3, PosH across tiles 5..6 and 24..25 with Gate=2'b11 and counts 12/08:
  - EnaTimer bits match the glyph rows of "1","2","0","8" with 3-cycle latency.
  - Drop Gate[0] → EnaTimer[0]=0.
- With TEMPORIZADOR_BLANK_LEADING_EN and count 05: tile 5 never asserts and tile 6 draws "5". Without the macro, tile 5 draws "0".
- Assert Reset during RUN at count 09 → count 0, IDLE, Expired=0, EnaTimer=0 for the 3 cycles after release.
